// File: rtl/noc_input_port_vc.sv
`default_nettype none
// ============================================================================
// Module   : noc_input_port_vc
// Purpose  : Router input port. It holds per-VC FIFOs and tracks the route of
//            each packet. It returns credits, arbitrates between VCs in
//            round-robin order and drives a registered output stage that
//            honours backpressure. Define NOC_YX_ROUTING_EN for YX routing;
//            the default is XY routing.
// Revision : 1.0
// ============================================================================
module noc_input_port_vc #(
   parameter logic [3:0] ADDRESS  = 4'b0000,
   parameter int         FLIT_W   = 32,
   parameter int         NUM_VC   = 2,
   parameter int         VC_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [FLIT_W-1:0]         flit_in,
   input  logic                      flit_in_valid,
   input  logic [$clog2(NUM_VC)-1:0] flit_in_vc,
   output logic                      credit_out_valid,
   output logic [$clog2(NUM_VC)-1:0] credit_out_vc,
   output logic [FLIT_W-1:0]         flit_out,
   output logic                      flit_out_valid,
   output logic [$clog2(NUM_VC)-1:0] flit_out_vc,
   output logic [2:0]                flit_out_gate,
   input  logic                      out_ready,
   output logic                      error
);

   localparam int VCW = $clog2(NUM_VC);
   localparam int PW  = $clog2(VC_DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(VC_DEPTH);
   localparam logic [2:0] GATE_LOCAL = 3'd0;
   localparam logic [2:0] GATE_NORTH = 3'd1;
   localparam logic [2:0] GATE_SOUTH = 3'd2;
   localparam logic [2:0] GATE_EAST  = 3'd3;
   localparam logic [2:0] GATE_WEST  = 3'd4;
   localparam logic [1:0] CUR_X = ADDRESS[3:2];
   localparam logic [1:0] CUR_Y = ADDRESS[1:0];

   function automatic logic [2:0] compute_route(input logic [3:0] dst);
      logic [2:0] gate;
      gate = GATE_LOCAL;
`ifdef NOC_YX_ROUTING_EN
      if (dst[1:0] > CUR_Y)      gate = GATE_NORTH;
      else if (dst[1:0] < CUR_Y) gate = GATE_SOUTH;
      else if (dst[3:2] > CUR_X) gate = GATE_EAST;
      else if (dst[3:2] < CUR_X) gate = GATE_WEST;
`else
      if (dst[3:2] > CUR_X)      gate = GATE_EAST;
      else if (dst[3:2] < CUR_X) gate = GATE_WEST;
      else if (dst[1:0] > CUR_Y) gate = GATE_NORTH;
      else if (dst[1:0] < CUR_Y) gate = GATE_SOUTH;
`endif
      return gate;
   endfunction

   logic [FLIT_W-1:0] mem        [NUM_VC][VC_DEPTH];
   logic [PW-1:0]     rd_ptr     [NUM_VC];
   logic [PW-1:0]     wr_ptr     [NUM_VC];
   logic [CW-1:0]     count      [NUM_VC];
   logic [2:0]        route_gate [NUM_VC];
   logic [NUM_VC-1:0] route_valid;
   logic [VCW-1:0]    rr_ptr;

   logic [NUM_VC-1:0] nonempty, full, push, pop, overflow_vec;
   logic              load_en, grant_valid, deq;
   logic              head_is_head, head_is_tail, orphan, missing_tail, forward;
   logic [VCW-1:0]    grant_vc, next_rr;
   logic [VCW:0]      arb_idx;
   logic [FLIT_W-1:0] head_flit;
   logic [2:0]        head_route, fwd_gate;

   generate
      for (genvar v = 0; v < NUM_VC; v++) begin : g_vc_status
         assign nonempty[v]     = (count[v] != '0);
         assign full[v]         = (count[v] == FULL_COUNT);
         assign pop[v]          = deq && (grant_vc == VCW'(v));
         // A full VC still accepts a write when it is dequeued on the same edge
         assign push[v]         = flit_in_valid && (flit_in_vc == VCW'(v)) && (!full[v] || pop[v]);
         assign overflow_vec[v] = flit_in_valid && (flit_in_vc == VCW'(v)) && full[v] && !pop[v];
      end
   endgenerate

   // Scan from the highest offset down so the nearest non-empty VC to rr_ptr wins
   always_comb begin
      grant_valid = 1'b0;
      grant_vc    = '0;
      arb_idx     = '0;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         arb_idx = {1'b0, rr_ptr} + (VCW+1)'(i);
         if (arb_idx >= (VCW+1)'(NUM_VC)) arb_idx = arb_idx - (VCW+1)'(NUM_VC);
         if (nonempty[arb_idx[VCW-1:0]]) begin
            grant_valid = 1'b1;
            grant_vc    = arb_idx[VCW-1:0];
         end
      end
   end

   assign load_en      = !flit_out_valid || out_ready;
   assign deq          = load_en && grant_valid;
   assign head_flit    = mem[grant_vc][rd_ptr[grant_vc]];
   assign head_is_head = head_flit[FLIT_W-2];
   assign head_is_tail = head_flit[FLIT_W-1];
   assign head_route   = compute_route(head_flit[FLIT_W-3:FLIT_W-6]);
   assign orphan       = deq && !head_is_head && !route_valid[grant_vc];
   assign missing_tail = deq && head_is_head && route_valid[grant_vc];
   assign forward      = deq && !orphan;
   assign fwd_gate     = head_is_head ? head_route : route_gate[grant_vc];
   assign next_rr      = (grant_vc == VCW'(NUM_VC - 1)) ? '0 : grant_vc + 1'b1;

   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (push[v]) mem[v][wr_ptr[v]] <= flit_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         route_valid <= '0;
         for (int v = 0; v < NUM_VC; v++) begin
            rd_ptr[v]     <= '0;
            wr_ptr[v]     <= '0;
            count[v]      <= '0;
            route_gate[v] <= GATE_LOCAL;
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
            if (pop[v]) begin
               rd_ptr[v] <= rd_ptr[v] + 1'b1;
               if (head_is_head) begin
                  route_valid[v] <= !head_is_tail;
                  route_gate[v]  <= head_route;
               end else if (head_is_tail) begin
                  route_valid[v] <= 1'b0;
               end
            end
            count[v] <= count[v] + CW'(push[v]) - CW'(pop[v]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flit_out         <= '0;
         flit_out_valid   <= 1'b0;
         flit_out_vc      <= '0;
         flit_out_gate    <= GATE_LOCAL;
         credit_out_valid <= 1'b0;
         credit_out_vc    <= '0;
         error            <= 1'b0;
         rr_ptr           <= '0;
      end else begin
         credit_out_valid <= deq;
         if (deq) begin
            credit_out_vc <= grant_vc;
            rr_ptr        <= next_rr;
         end
         error <= orphan || missing_tail || (|overflow_vec);
         // Dropped orphans leave the output stage empty for this cycle
         if (load_en) begin
            flit_out_valid <= forward;
            if (forward) begin
               flit_out      <= head_flit;
               flit_out_vc   <= grant_vc;
               flit_out_gate <= fwd_gate;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/noc_input_port_vc.md
Name: noc_input_port_vc

Overview:
- Parametrised next-generation router input port: N virtual channels, configurable depth and flit width.
- Adds credit return, a registered output stage with backpressure, per-VC packet route tracking, and round-robin switch arbitration.
- Sits between an upstream link (valid + VC tag, credit-based) and the router crossbar.
- Emits one routed flit per cycle, tagged with its output gate and VC.

Parameters:
- ADDRESS, 4'b0000, this router's coordinate; [3:2] = x, [1:0] = y.
- FLIT_W, 32, flit width in bits; minimum 8.
- NUM_VC, 2, number of virtual channels, 2..8.
- VC_DEPTH, 4, flits per VC FIFO; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flit_in  in  FLIT_W  incoming flit.
- flit_in_valid  in  1  flit_in is valid this cycle.
- flit_in_vc  in  clog2(NUM_VC)  target VC of flit_in.
- credit_out_valid  out  1  one-cycle pulse: one slot freed.
- credit_out_vc  out  clog2(NUM_VC)  VC whose slot was freed.
- flit_out  out  FLIT_W  registered outgoing flit.
- flit_out_valid  out  1  flit_out holds a valid flit.
- flit_out_vc  out  clog2(NUM_VC)  VC that flit_out came from.
- flit_out_gate  out  3  output gate: 0 local, 1 north, 2 south, 3 east, 4 west.
- out_ready  in  1  crossbar accepts flit_out this cycle.
- error  out  1  one-cycle pulse on overflow or orphan body/tail flit.

Behaviour:

Flit format:
- [FLIT_W-1:FLIT_W-2] type: 01 head, 00 body, 10 tail, 11 head+tail (single-flit packet).
- Head flits carry the destination in [FLIT_W-3:FLIT_W-6] as x = upper 2 bits, y = lower 2 bits.

Reset:
- All FIFOs empty; all route-valid bits cleared.
- Round-robin pointer = VC0.
- flit_out = 0, flit_out_valid = 0, flit_out_vc = 0, flit_out_gate = 0.
- credit_out_valid = 0, credit_out_vc = 0, error = 0.
- Reset asserted mid-packet discards all buffered flits and routes. No credits are returned for discarded flits; upstream reinitialises its credits on reset.

Write:
- On an edge with flit_in_valid = 1, flit_in is pushed into VC flit_in_vc.
- If that VC is full and is not dequeued on the same edge: the flit is dropped and error pulses the next cycle.
- If that VC is full and is dequeued on the same edge: the write is accepted.

Routing (XY):
- x_dst > x_cur: east (3). x_dst < x_cur: west (4).
- Otherwise y_dst > y_cur: north (1). y_dst < y_cur: south (2).
- Otherwise: local (0).

Per-VC route register:
- Loaded when a head or head+tail flit is dequeued.
- Body and tail flits use the latched route.
- Dequeuing a tail or head+tail flit clears route-valid.
- A body or tail flit at a FIFO head with route-valid = 0 is dequeued and dropped: credit is returned and error pulses.
- A head flit dequeued while route-valid = 1 (missing tail) overwrites the route and pulses error; the flit is forwarded.

Output stage:
- Load is enabled when flit_out_valid = 0 or out_ready = 1.
- When load is enabled, the round-robin arbiter picks the first non-empty VC starting at the pointer.
- That VC's head flit is dequeued into flit_out on the edge; gate and vc are registered alongside.
- The pointer then moves to granted VC + 1, wrapping at NUM_VC.
- If no VC is non-empty, flit_out_valid goes to 0 (only if out_ready or already empty).
- While flit_out_valid = 1 and out_ready = 0, all output registers hold.

Latency and throughput:
- A flit written at edge k appears on flit_out after edge k+1 if the output stage is free.
- Sustained throughput: 1 flit per cycle.

Credits:
- Every dequeue (forwarded or dropped) raises credit_out_valid for exactly the next cycle, with credit_out_vc = the dequeued VC.
- At most one credit per cycle.

FIFO storage:
- Circular read/write pointers of clog2(VC_DEPTH) bits that wrap modulo VC_DEPTH.
- Occupancy counter of clog2(VC_DEPTH)+1 bits; it never exceeds VC_DEPTH.

Optional Feature:
- Macro: NOC_YX_ROUTING_EN.
- When defined: routing is YX. The y comparison decides north/south first; x decides east/west only when y is equal.
- When undefined: XY routing as specified above.
- Nothing else changes.

Test Plan:
1. Reset, then with ADDRESS = 4'b0101, write a head+tail flit on VC0 with dst 4'b1101 → flit_out_valid = 1 one cycle later, gate = 3 (east), vc = 0; credit_out_valid = 1 for VC0 in the same cycle. With NOC_YX_ROUTING_EN and dst 4'b1110 → gate = 1 (north).
2. Send a head/body/tail packet on VC1 with dst = ADDRESS, out_ready held at 1 → three consecutive flit_out cycles, each with gate = 0, and three credits returned for VC1.
3. Fill VC0 and VC1 with 4 flits each, out_ready = 1 → output alternates VC0, VC1, VC0, … for 8 cycles.
4. Hold out_ready = 0 for 5 cycles with flit_out_valid = 1 → flit_out, gate and vc are stable and no credits are issued; releasing out_ready resumes at 1 flit per cycle.
5. Write 5 flits to VC0 with VC_DEPTH = 4 and the output stalled → the 5th flit is dropped, error pulses once, and the FIFO still holds flits 1-4 in order.
6. Write a body flit to an idle VC → the flit is not forwarded, error pulses once, and one credit is returned for that VC.
